// File: rtl/fnd_display_arbiter.sv
// fnd_display_arbiter: per-digit scan tick generator and frame-aligned source arbiter for the 4-digit FND.
// Optional build macro FND_BLINK_EN: blinks oBlank while a notify word is on display.
module fnd_display_arbiter #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1_000,
    parameter int HOLD_MS  = 2_000,
    parameter int BLINK_HZ = 2
) (
    input  logic        iClk,
    input  logic        iRstn,
    input  logic [13:0] iBaseDigit,
    input  logic        iSwValid,
    input  logic [13:0] iSwDigit,
    input  logic        iNotifyReq,
    input  logic [13:0] iNotifyDigit,
    output logic        oNotifyAck,
    output logic        oScanTick,
    output logic [13:0] oDigit,
    output logic [1:0]  oSrcSel,
    output logic        oBlank
);

    localparam int DIV        = CLK_HZ / SCAN_HZ;
    localparam int PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HOLD_TICKS = HOLD_MS * SCAN_HZ / 1000;
    localparam int HW         = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

    typedef enum logic [1:0] {
        ST_BASE   = 2'd0,
        ST_SW     = 2'd1,
        ST_NOTIFY = 2'd2
    } state_t;

    function automatic logic [6:0] clamp_field(input logic [6:0] f);
        return (f > 7'd99) ? 7'd99 : f;
    endfunction

    function automatic logic [13:0] clamp_word(input logic [13:0] w);
        return {clamp_field(w[13:7]), clamp_field(w[6:0])};
    endfunction

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_mirror;
    logic [HW-1:0]   r_hold;
    logic            r_pending;
    logic            r_req_seen;
    logic            r_ack;
    logic [13:0]     r_ntf_digit;
    logic [13:0]     r_digit;

    logic            w_tick;
    logic            w_fb;
    logic            w_accept;
    logic            w_expire;
    logic            w_pend_eff;
    logic            w_enter;
    logic [13:0]     w_ntf_word;
    state_t          w_next;
    logic [13:0]     w_sel_word;
    logic            w_sel_valid;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_fb       = w_tick && (r_mirror == 2'd3);
    assign w_accept   = iNotifyReq && !r_req_seen;
    // The last hold tick and a frame boundary can coincide; the boundary must already see it expired.
    assign w_expire   = (r_state == ST_NOTIFY) && w_tick && (r_hold == HOLD_ONE);
    assign w_pend_eff = w_accept || (r_pending && !w_expire);
    assign w_ntf_word = w_accept ? iNotifyDigit : r_ntf_digit;
    assign w_enter    = w_fb && (w_next == ST_NOTIFY) && (r_state != ST_NOTIFY);

    always_comb begin
        w_next = r_state;
        if (w_fb) begin
            if (w_pend_eff)
                w_next = ST_NOTIFY;
            else if (iSwValid)
                w_next = ST_SW;
            else
                w_next = ST_BASE;
        end
    end

    always_comb begin
        w_sel_word  = iBaseDigit;
        w_sel_valid = 1'b1;
        case (w_next)
            ST_SW: begin
                w_sel_word  = iSwDigit;
                w_sel_valid = iSwValid;
            end
            ST_NOTIFY: w_sel_word = w_ntf_word;
            default:   w_sel_word = iBaseDigit;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_state     <= ST_BASE;
            r_presc     <= '0;
            r_mirror    <= 2'd0;
            r_hold      <= '0;
            r_pending   <= 1'b0;
            r_req_seen  <= 1'b0;
            r_ack       <= 1'b0;
            r_ntf_digit <= 14'd0;
            r_digit     <= 14'd0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick)
                r_mirror <= r_mirror + 2'd1;

            r_ack <= w_accept;
            if (w_accept)
                r_req_seen <= 1'b1;
            else if (!iNotifyReq)
                r_req_seen <= 1'b0;
            if (w_accept)
                r_ntf_digit <= iNotifyDigit;
            r_pending <= w_pend_eff;

            if (w_enter || (w_accept && r_state == ST_NOTIFY))
                r_hold <= HOLD_LOAD;
            else if (r_state == ST_NOTIFY && w_tick && r_hold != '0)
                r_hold <= r_hold - 1'b1;

            if (w_fb)
                r_state <= w_next;
            // A dropped stopwatch keeps its last word on screen until the frame ends.
            if (w_tick && w_sel_valid)
                r_digit <= clamp_word(w_sel_word);
        end
    end

`ifdef FND_BLINK_EN
    localparam int BLINK_T = SCAN_HZ / (2 * BLINK_HZ);
    localparam int BW      = (BLINK_T > 1) ? $clog2(BLINK_T) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_T - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blank;

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (w_fb && (w_next != ST_NOTIFY || r_state != ST_NOTIFY)) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (r_state == ST_NOTIFY && w_tick) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign oBlank = r_blank;
`else
    assign oBlank = 1'b0 && (BLINK_HZ > 0);
`endif

    assign oNotifyAck = r_ack;
    assign oScanTick  = w_tick;
    assign oDigit     = r_digit;
    assign oSrcSel    = r_state;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Bench for fnd_display_arbiter: directed scenarios plus random traffic, checked cycle by cycle
// against a tick/deadline-based reference model.
module tb_fnd_display_arbiter;

    localparam int CLK_HZ   = 1000;
    localparam int SCAN_HZ  = 100;
    localparam int HOLD_MS  = 200;
    localparam int BLINK_HZ = 25;
    localparam int DIV      = CLK_HZ / SCAN_HZ;
    localparam int HOLD     = HOLD_MS * SCAN_HZ / 1000;
    localparam int BT       = SCAN_HZ / (2 * BLINK_HZ);

    logic        clk = 1'b0;
    logic        rstn;
    logic [13:0] base, swd, nd;
    logic        swv, req;
    logic        ack, tick, blank;
    logic [13:0] digit;
    logic [1:0]  src;

    always #5 clk = ~clk;

    fnd_display_arbiter #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ),
        .HOLD_MS (HOLD_MS),
        .BLINK_HZ(BLINK_HZ)
    ) dut (
        .iClk        (clk),
        .iRstn       (rstn),
        .iBaseDigit  (base),
        .iSwValid    (swv),
        .iSwDigit    (swd),
        .iNotifyReq  (req),
        .iNotifyDigit(nd),
        .oNotifyAck  (ack),
        .oScanTick   (tick),
        .oDigit      (digit),
        .oSrcSel     (src),
        .oBlank      (blank)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_acks   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: time measured in cycles since reset and tick indices,
    // the notify hold expressed as an absolute tick deadline.
    int          m_c, m_nt, m_src, m_deadline, m_entry;
    logic [13:0] m_digit, m_ntf;
    bit          m_ack, m_held, m_pend, m_blank;

    function automatic logic [13:0] clampw(input logic [13:0] w);
        int hi, lo;
        hi = int'(w[13:7]);
        lo = int'(w[6:0]);
        if (hi > 99) hi = 99;
        if (lo > 99) lo = 99;
        return 14'(hi * 128 + lo);
    endfunction

    task automatic model_step();
        bit is_tick, fb, accept, expired, pend;
        int ti, nsrc;
        logic [13:0] ntf;
        if (!rstn) begin
            m_c = 0; m_nt = 0; m_src = 0; m_deadline = 0; m_entry = 0;
            m_digit = 14'd0; m_ntf = 14'd0;
            m_ack = 0; m_held = 0; m_pend = 0; m_blank = 0;
            return;
        end
        is_tick = (m_c % DIV) == DIV - 1;
        ti      = m_nt + (is_tick ? 1 : 0);
        fb      = is_tick && (ti % 4 == 0);
        accept  = req && !m_held;
        expired = (m_src == 2) && is_tick && m_pend && (ti == m_deadline);
        pend    = accept || (m_pend && !expired);
        ntf     = accept ? nd : m_ntf;
        nsrc    = m_src;
        if (fb) nsrc = pend ? 2 : (swv ? 1 : 0);
        if (is_tick) begin
            if (nsrc == 0) m_digit = clampw(base);
            else if (nsrc == 1) begin
                if (swv) m_digit = clampw(swd);
            end else m_digit = clampw(ntf);
        end
        if (accept && m_src == 2) m_deadline = ti + HOLD;
        if (fb && nsrc == 2 && m_src != 2) begin
            m_deadline = ti + HOLD;
            m_entry    = ti;
        end
        m_ack = accept;
        if (accept) m_held = 1;
        else if (!req) m_held = 0;
        m_pend = pend;
        m_ntf  = ntf;
        m_src  = nsrc;
        m_nt   = ti;
        m_c    = m_c + 1;
`ifdef FND_BLINK_EN
        m_blank = (m_src == 2) ? ((((m_nt - m_entry) / BT) % 2) != 0) : 1'b0;
`else
        m_blank = 1'b0;
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        if (ack) n_acks++;
        chk("tick",  32'(tick),  32'((m_c % DIV) == DIV - 1));
        chk("ack",   32'(ack),   32'(m_ack));
        chk("src",   32'(src),   32'(m_src));
        chk("digit", 32'(digit), 32'(m_digit));
        chk("blank", 32'(blank), 32'(m_blank));
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_c != target && guard < 5000) begin
            step();
            guard++;
        end
        chk("run_to_reached", 32'(m_c), 32'(target));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_digit"}, 32'(digit), 32'd0);
        chk({tag, "_src"},   32'(src),   32'd0);
        chk({tag, "_ack"},   32'(ack),   32'd0);
        chk({tag, "_tick"},  32'(tick),  32'd0);
        chk({tag, "_blank"}, 32'(blank), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; base = 14'd0; swv = 1'b0; swd = 14'd0; req = 1'b0; nd = 14'd0;
        m_c = 0; m_nt = 0; m_src = 0; m_deadline = 0; m_entry = 0;
        m_digit = 14'd0; m_ntf = 14'd0; m_ack = 0; m_held = 0; m_pend = 0; m_blank = 0;
        repeat (3) step();
        chk_all_zero("rst");

        rstn = 1'b1;
        base = {7'd12, 7'd34};
        run_to(9);
        chk("t1_first_tick", 32'(tick), 32'd1);
        run_to(40);
        chk("t1_digit", 32'(digit), 32'h0622);
        chk("t1_src",   32'(src),   32'd0);

        run_to(55);
        swv = 1'b1; swd = {7'd1, 7'd2};
        run_to(79);
        chk("t2_src_hold", 32'(src), 32'd0);
        run_to(80);
        chk("t2_src",   32'(src),   32'd1);
        chk("t2_digit", 32'(digit), 32'h0082);

        run_to(85);
        req = 1'b1; nd = {7'd5, 7'd6};
        n_acks = 0;
        run_to(120);
        chk("t3_src",   32'(src),   32'd2);
        chk("t3_digit", 32'(digit), 32'h0286);
        run_to(300);
        chk("t3_one_ack", 32'(n_acks), 32'd1);
        req = 1'b0;
        run_to(319);
        chk("t3_still_ntf", 32'(src), 32'd2);
        run_to(320);
        chk("t3_back_sw", 32'(src), 32'd1);

        run_to(330);
        req = 1'b1; nd = {7'd1, 7'd1};
        run_to(340);
        req = 1'b0;
        run_to(360);
        chk("t4_src", 32'(src), 32'd2);
`ifdef FND_BLINK_EN
        run_to(370);
        chk("t6_blank_lo", 32'(blank), 32'd0);
        run_to(380);
        chk("t6_blank_hi", 32'(blank), 32'd1);
`endif
        run_to(400);
        chk("t4_digit1", 32'(digit), 32'h0081);
        run_to(462);
        req = 1'b1; nd = {7'd99, 7'd0};
        run_to(470);
        req = 1'b0;
        chk("t4_digit2", 32'(digit), 32'h3180);
        run_to(560);
        chk("t4_no_exit", 32'(src), 32'd2);
        run_to(670);
        chk("t4_reloaded", 32'(src), 32'd2);
        run_to(680);
        chk("t4_exit", 32'(src), 32'd1);

        run_to(685);
        swv = 1'b0;
        run_to(720);
        chk("t2_sw_off", 32'(src), 32'd0);
        run_to(721);
        base = {7'd120, 7'd100};
        run_to(730);
        chk("t5_clamp", 32'(digit), 32'h31E3);

        run_to(740);
        req = 1'b1; nd = {7'd3, 7'd4};
        run_to(745);
        req = 1'b0;
        run_to(765);
        chk("t6_in_ntf", 32'(src), 32'd2);
        rstn = 1'b0;
        step();
        chk_all_zero("t6_rst");
        rstn = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 199) == 0) swv = ~swv;
            if ($urandom_range(0, 49) == 0)  swd = 14'($urandom);
            if ($urandom_range(0, 99) == 0)  base = 14'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                req = 1'b1;
                nd  = 14'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                req = 1'b0;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
